// File: rtl/if_id_fetch_queue_if.sv
// Handshake bundle between the fetch stage, the IF/ID queue and decode.
// slave: the queue side. master: the fetch/decode (or testbench) side.
interface if_id_fetch_queue_if #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] instruction_in;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] instruction_out;
  logic [CW-1:0]    count;

  modport slave (
    input  flush, in_valid, pc_in, instruction_in, out_ready,
    output in_ready, out_valid, pc_out, instruction_out, count
  );

  modport master (
    output flush, in_valid, pc_in, instruction_in, out_ready,
    input  in_ready, out_valid, pc_out, instruction_out, count
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: buffers {pc, instruction} pairs from fetch and
// presents the oldest pair to decode (show-ahead). A taken branch (flush)
// discards everything; fetch freezes while the queue is full.
module if_id_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  if_id_fetch_queue_if.slave  q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] pc_mem_q [DEPTH];
  logic [WIDTH-1:0] pc_mem_d [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-1:0] instr_mem_d [DEPTH];

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Explicit wrap compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // in_ready depends on count only, so there is no out_ready -> in_ready path;
  // a full queue being popped accepts the next push one cycle later.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = q.in_valid & in_ready;
  assign pop       = out_valid & q.out_ready;

  assign q.in_ready        = in_ready;
  assign q.out_valid       = out_valid;
  assign q.count           = count_q;
  assign q.pc_out          = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign q.instruction_out = out_valid ? instr_mem_q[rd_ptr_q] : '0;

  // Next-state: flush wins over any push/pop in the same cycle.
  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (q.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = q.pc_in;
        instr_mem_d[wr_ptr_q] = q.instruction_in;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers with asynchronous reset; storage is cleared as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for the IF/ID fetch queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_if_id_fetch_queue;
  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: the list of buffered {pc, instr} pairs, oldest first.
  logic [2*WIDTH-1:0] model [$];

  if_id_fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  if_id_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model says it should be.
  task automatic check_state(input string tag);
    logic [WIDTH-1:0] exp_pc;
    logic [WIDTH-1:0] exp_ins;
    exp_pc  = '0;
    exp_ins = '0;
    if (model.size() != 0) begin
      exp_pc  = model[0][2*WIDTH-1:WIDTH];
      exp_ins = model[0][WIDTH-1:0];
    end
    check({tag, ".count"},     WIDTH'(bus.count),     WIDTH'(model.size()));
    check({tag, ".out_valid"}, WIDTH'(bus.out_valid), WIDTH'(model.size() != 0));
    check({tag, ".in_ready"},  WIDTH'(bus.in_ready),  WIDTH'(model.size() < DEPTH));
    check({tag, ".pc_out"},    bus.pc_out,            exp_pc);
    check({tag, ".instr_out"}, bus.instruction_out,   exp_ins);
  endtask

  // One clock cycle: drive inputs (called just after a falling edge),
  // advance the model at the rising edge, check at the next falling edge.
  task automatic step(input string tag, input logic fl, input logic iv,
                      input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins,
                      input logic ordy);
    bit push_m;
    bit pop_m;
    bus.flush          = fl;
    bus.in_valid       = iv;
    bus.pc_in          = pc;
    bus.instruction_in = ins;
    bus.out_ready      = ordy;
    push_m = iv && (model.size() < DEPTH);
    pop_m  = ordy && (model.size() != 0);
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      if (pop_m)  void'(model.pop_front());
      if (push_m) model.push_back({pc, ins});
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.pc_in = '0;   bus.instruction_in = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_state("post_reset");

    // Reset then fill
    step("fill1", 0, 1, 32'd4, 32'hE3A00001, 0);
    step("fill2", 0, 1, 32'd8, 32'hE3A01002, 0);
    check("fill.head_pc", bus.pc_out, 32'd4);
    check("fill.in_ready_low", WIDTH'(bus.in_ready), 32'd0);

    // Full and stalled, then drain one and accept pc 12
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 32'd12, 32'hE3A0200C, 0);
    step("drain1", 0, 1, 32'd12, 32'hE3A0200C, 1);
    check("drain1.head_pc", bus.pc_out, 32'd8);
    step("accept12", 0, 1, 32'd12, 32'hE3A0200C, 0);

    // Streaming from empty
    step("flush_prep", 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("stream", 0, 1, WIDTH'(4 * (i + 1)), WIDTH'(32'hE1A00000 + i), 1);
    step("stream_tail", 0, 0, 0, 0, 1);

    // Flush with simultaneous push
    step("fl_a", 0, 1, 32'd4, 32'h11, 0);
    step("fl_b", 0, 1, 32'd8, 32'h22, 0);
    step("flush_push", 1, 1, 32'd12, 32'h33, 1);
    check("flush.pc_zero", bus.pc_out, 32'd0);
    step("after_flush", 0, 1, 32'h40, 32'h44, 0);
    check("after_flush.head", bus.pc_out, 32'h40);

    // Underflow guard
    step("uf_empty", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("underflow", 0, 0, 0, 0, 1);
    step("uf_push", 0, 1, 32'd4, 32'hABCD, 0);

    // Asynchronous reset between edges
    step("ar_fill", 0, 1, 32'd8, 32'h1234, 0);
    #2 rst = 1'b1;
    #1;
    model.delete();
    check_state("async_reset");
    @(negedge clk);
    rst = 1'b0;
    step("ar_push", 0, 1, 32'h100, 32'h5555AAAA, 0);
    step("ar_pop", 0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           $urandom, $urandom, $urandom_range(0, 1) == 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Decoupling queue between the instruction-fetch stage and the decode stage of the 5-stage pipeline.
- Buffers {pc, instruction} pairs pushed by fetch and presents the oldest pair to decode.
- Drives fetch's freeze from its full condition.
- Discards all buffered entries on a taken branch.

Parameters:
DEPTH, 2, number of {pc, instruction} entries; integer >= 2, power of two not required
WIDTH, 32, width of pc and of instruction

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
flush  input  1  taken-branch kill; tie to branch_taken
in_valid  input  1  fetch has a valid pair this cycle
pc_in  input  WIDTH  pc of the fetched instruction (pc+4 value as produced by fetch)
instruction_in  input  WIDTH  fetched instruction word
in_ready  output  1  queue can accept a pair; fetch freeze = ~in_ready
out_ready  input  1  decode consumes the head pair this cycle; tie to ~hazard
out_valid  output  1  head pair is valid
pc_out  output  WIDTH  head pc; 0 when empty
instruction_out  output  WIDTH  head instruction; 0 when empty (bubble/NOP)
count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (asynchronous assert, synchronous release):
  - count=0, read/write pointers=0, storage cleared to 0.
  - out_valid=0, pc_out=0, instruction_out=0, in_ready=1.
- Push: in_valid & in_ready at a rising edge writes {pc_in, instruction_in} at the write pointer and advances it.
- Pop: out_valid & out_ready at a rising edge advances the read pointer.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0 with an explicit compare, so non-power-of-two DEPTH works.
- count: count_next = count + push - pop.
  - push and pop in the same cycle leaves count unchanged and both pointers advance.
- in_ready = (count < DEPTH).
  - Combinational from count only; no path from out_ready.
  - When full, a simultaneous pop does not allow a push that cycle; in_ready rises the cycle after.
- out_valid = (count != 0).
- pc_out/instruction_out show the storage entry at the read pointer (show-ahead) when count != 0; otherwise 0.
- Latency: a pair pushed into an empty queue at edge N is on the outputs with out_valid=1 after edge N (same cycle as count=1). There is no bypass from input to output in the same cycle.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush or reset.
- Flush (synchronous, highest priority):
  - At the edge where flush=1: count=0, both pointers=0.
  - Any push or pop in that cycle is ignored.
  - After the edge: out_valid=0, outputs=0, in_ready=1.
  - Storage contents need not be cleared.
- Flush on empty queue: no effect beyond the pointer reset.
- out_ready with out_valid=0: ignored; count never underflows.
- in_valid with in_ready=0: ignored; fetch holds its pc via freeze, so no pair is lost.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk.

Test Plan:
- Reset then fill: rst pulse; push (pc 4, instr 0xE3A00001), (pc 8, instr 0xE3A01002) with out_ready=0 -> count 1 then 2; in_ready=0 after the 2nd edge; pc_out=4, instruction_out=0xE3A00001 throughout.
- Full and stalled: full queue, in_valid=1 with new pair pc 12, out_ready=0 for 3 cycles -> count stays 2, pc 12 not stored. Assert out_ready=1 -> next edge pc_out=8, count=1, in_ready=1; following edge stores pc 12.
- Streaming: in_valid=1 and out_ready=1 every cycle with pc 4, 8, 12, 16, 20 -> count holds 1 after the first edge; pc_out sequence 4, 8, 12, 16, 20 one per cycle with no gaps; pointers wrap correctly.
- Flush with simultaneous push: count=2 holding pc 4, 8; flush=1 and in_valid=1 with pc 12 in the same cycle -> after the edge count=0, out_valid=0, pc_out=0, instruction_out=0, in_ready=1. Next push pc 0x40 appears as head pc_out=0x40.
- Underflow guard: empty queue, out_ready=1 for 4 cycles -> count stays 0, outputs stay 0. Then a single push of pc 4 -> out_valid=1 the next cycle.
- Async reset mid-stream: count=2; assert rst between clock edges -> out_valid, count, pc_out and instruction_out go to 0 before the next edge. After release, the first push lands in entry 0 and reads back correctly.
